// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receive path.
// Holds the frame state enum, scancode prefixes, device responses and ps2_key field indices.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_REL    = 8'hF0;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_BAT    = 8'hAA;
    localparam logic [7:0] SC_ECHO   = 8'hEE;
    localparam logic [7:0] SC_RESEND = 8'hFE;

    // Bytes following E1 that belong to the pause-key sequence
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    localparam int KEY_TOGGLE  = 10;
    localparam int KEY_PRESSED = 9;
    localparam int KEY_EXT     = 8;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus stability filter for a PS/2 line.
// Emits a one-cycle strobe when the filtered level falls from 1 to 0.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic line_in,
    output logic fall_strobe
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    sync;
    logic          filt;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            sync        <= 2'b11;
            filt        <= 1'b1;
            cnt         <= '0;
            fall_strobe <= 1'b0;
        end else begin
            sync        <= {sync[0], line_in};
            fall_strobe <= 1'b0;
            if (sync[1] == filt) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                // FILTER_LEN consecutive differing samples: accept; old level 1 means a fall
                cnt         <= '0;
                filt        <= sync[1];
                fall_strobe <= filt;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: frame FSM, mid-frame timeout and E0/F0/E1 prefix handling.
// Publishes each key event on ps2_key as {toggle, pressed, extended, scancode}.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 48000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        parity_err,
    output logic        frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic       bit_stb;
    logic [1:0] data_sync;
    logic       bit_val;

    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .line_in    (ps2_clk),
        .fall_strobe(bit_stb)
    );

    always_ff @(posedge clk_sys) begin
        if (!reset_n) data_sync <= 2'b11;
        else          data_sync <= {data_sync[0], ps2_data};
    end

    assign bit_val = data_sync[1];

    ps2_state_e    state, state_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shreg, shreg_n;
    logic          par_bit, par_bit_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic          frame_err_n, parity_err_n;
    logic          byte_vld, byte_vld_n;
    logic          tout, tout_n;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            tcnt       <= '0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            byte_vld   <= 1'b0;
            tout       <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shreg      <= shreg_n;
            par_bit    <= par_bit_n;
            tcnt       <= tcnt_n;
            frame_err  <= frame_err_n;
            parity_err <= parity_err_n;
            byte_vld   <= byte_vld_n;
            tout       <= tout_n;
        end
    end

    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        shreg_n      = shreg;
        par_bit_n    = par_bit;
        tcnt_n       = tcnt;
        frame_err_n  = 1'b0;
        parity_err_n = 1'b0;
        byte_vld_n   = 1'b0;
        tout_n       = 1'b0;

        // Abort on the edge where the idle count would reach TIMEOUT_CYC
        if (state == IDLE || bit_stb) begin
            tcnt_n = '0;
        end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
            tcnt_n      = '0;
            state_n     = IDLE;
            frame_err_n = 1'b1;
            tout_n      = 1'b1;
        end else begin
            tcnt_n = tcnt + 1'b1;
        end

        if (bit_stb) begin
            unique case (state)
                IDLE: begin
                    if (!bit_val) begin
                        state_n   = DATA;
                        bit_cnt_n = '0;
                    end else begin
                        frame_err_n = 1'b1;
                    end
                end
                DATA: begin
                    shreg_n   = {bit_val, shreg[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_n = PARITY;
                end
                PARITY: begin
                    par_bit_n = bit_val;
                    state_n   = STOP;
                end
                STOP: begin
                    if (!bit_val)                    frame_err_n  = 1'b1;
                    else if (^{shreg, par_bit} == 1'b0) parity_err_n = 1'b1;
                    else                             byte_vld_n   = 1'b1;
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    logic [2:0] skip_cnt;
    logic       ext, rel;

    // shreg is stable here: the next strobe is many cycles away
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            ps2_key  <= '0;
            skip_cnt <= '0;
            ext      <= 1'b0;
            rel      <= 1'b0;
        end else if (tout) begin
            skip_cnt <= '0;
            ext      <= 1'b0;
            rel      <= 1'b0;
        end else if (frame_err || parity_err) begin
            ext <= 1'b0;
            rel <= 1'b0;
        end else if (byte_vld) begin
            if (skip_cnt != 3'd0) begin
                skip_cnt <= skip_cnt - 3'd1;
            end else begin
                case (shreg)
                    SC_PAUSE: skip_cnt <= PAUSE_SKIP;
                    SC_EXT:   ext      <= 1'b1;
                    SC_REL:   rel      <= 1'b1;
                    SC_ACK, SC_BAT, SC_ECHO, SC_RESEND, 8'h00, 8'hFF: begin
                        ext <= 1'b0;
                        rel <= 1'b0;
                    end
                    default: begin
                        ps2_key <= {~ps2_key[KEY_TOGGLE], ~rel, ext, shreg};
                        ext     <= 1'b0;
                        rel     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed vector table, corner sequences,
// and randomized frames compared against a byte-level reference model.
`timescale 1ns/1ps
module tb_ps2_key_decoder;

    localparam int FILT = 8;
    localparam int TOUT = 600;
    localparam int HALF = 20;
    localparam int GAP  = 30;

    logic        clk_sys  = 1'b0;
    logic        reset_n  = 1'b0;
    logic        ps2_clk  = 1'b1;
    logic        ps2_data = 1'b1;
    logic [10:0] ps2_key;
    logic        parity_err;
    logic        frame_err;

    ps2_key_decoder #(
        .FILTER_LEN (FILT),
        .TIMEOUT_CYC(TOUT)
    ) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .ps2_key   (ps2_key),
        .parity_err(parity_err),
        .frame_err (frame_err)
    );

    always #21 clk_sys = ~clk_sys;

    int checks = 0, failures = 0;
    int perr_cnt = 0, ferr_cnt = 0, tog_cnt = 0, both_cnt = 0;
    logic prev_tog = 1'b0;

    always @(negedge clk_sys) begin
        if (reset_n) begin
            if (parity_err) perr_cnt++;
            if (frame_err) ferr_cnt++;
            if (parity_err && frame_err) both_cnt++;
            if (ps2_key[10] !== prev_tog) tog_cnt++;
        end
        prev_tog = ps2_key[10];
    end

    // Reference model operating on whole received bytes
    logic        m_ext = 1'b0, m_rel = 1'b0;
    int          m_skip = 0;
    logic [10:0] m_key = '0;
    int          m_tog = 0, m_perr = 0, m_ferr = 0;

    task automatic model_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        if (bad_stop) begin
            m_ferr++; m_ext = 1'b0; m_rel = 1'b0;
        end else if (bad_par) begin
            m_perr++; m_ext = 1'b0; m_rel = 1'b0;
        end else if (m_skip > 0) begin
            m_skip--;
        end else if (b == 8'hE1) begin
            m_skip = 7;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_rel = 1'b1;
        end else if (b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF}) begin
            m_ext = 1'b0; m_rel = 1'b0;
        end else begin
            m_key = {~m_key[10], ~m_rel, m_ext, b};
            m_tog++;
            m_ext = 1'b0; m_rel = 1'b0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_key"}, 32'(ps2_key), 32'(m_key));
        check({tag, "_perr"}, perr_cnt, m_perr);
        check({tag, "_ferr"}, ferr_cnt, m_ferr);
        check({tag, "_tog"}, tog_cnt, m_tog);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic par;
        par = ~(^b) ^ bad_par;
        return {~bad_stop, par, b, 1'b0};
    endfunction

    // Data changes mid-way through the high phase, then the clock falls
    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            wait_cyc(HALF / 2);
            ps2_data = bits[i];
            wait_cyc(HALF / 2);
            ps2_clk = 1'b0;
            wait_cyc(HALF);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        send_bits(frame_bits(b, bad_par, bad_stop), 11);
        wait_cyc(HALF / 2);
        ps2_data = 1'b1;
        wait_cyc(GAP);
    endtask

    typedef struct {
        logic [7:0]  code;
        bit          bad_par;
        logic [10:0] exp_key;
        int          exp_perr;
    } vec_t;

    vec_t tbl[22];

    initial begin
        logic [7:0] b;
        bit bp, bs;
        int r;
        logic [7:0] resp[6];

        tbl[0]  = '{8'h1C, 1'b0, 11'h61C, 0};
        tbl[1]  = '{8'hF0, 1'b0, 11'h61C, 0};
        tbl[2]  = '{8'h1C, 1'b0, 11'h01C, 0};
        tbl[3]  = '{8'hE0, 1'b0, 11'h01C, 0};
        tbl[4]  = '{8'h75, 1'b0, 11'h775, 0};
        tbl[5]  = '{8'hE0, 1'b0, 11'h775, 0};
        tbl[6]  = '{8'hF0, 1'b0, 11'h775, 0};
        tbl[7]  = '{8'h75, 1'b0, 11'h175, 0};
        tbl[8]  = '{8'hE0, 1'b0, 11'h175, 0};
        tbl[9]  = '{8'h29, 1'b1, 11'h175, 1};
        tbl[10] = '{8'h29, 1'b0, 11'h629, 1};
        tbl[11] = '{8'hE1, 1'b0, 11'h629, 1};
        tbl[12] = '{8'h14, 1'b0, 11'h629, 1};
        tbl[13] = '{8'h77, 1'b0, 11'h629, 1};
        tbl[14] = '{8'hE1, 1'b0, 11'h629, 1};
        tbl[15] = '{8'hF0, 1'b0, 11'h629, 1};
        tbl[16] = '{8'h14, 1'b0, 11'h629, 1};
        tbl[17] = '{8'hF0, 1'b0, 11'h629, 1};
        tbl[18] = '{8'h77, 1'b0, 11'h629, 1};
        tbl[19] = '{8'h05, 1'b0, 11'h205, 1};
        tbl[20] = '{8'hFA, 1'b0, 11'h205, 1};
        tbl[21] = '{8'hAA, 1'b0, 11'h205, 1};

        resp[0] = 8'hFA; resp[1] = 8'hAA; resp[2] = 8'hEE;
        resp[3] = 8'hFE; resp[4] = 8'h00; resp[5] = 8'hFF;

        wait_cyc(5);
        check("reset_key", 32'(ps2_key), 32'h0);
        check("reset_perr_out", 32'(parity_err), 32'h0);
        check("reset_ferr_out", 32'(frame_err), 32'h0);
        reset_n = 1'b1;
        wait_cyc(20);

        for (int i = 0; i < 22; i++) begin
            send_frame(tbl[i].code, tbl[i].bad_par, 1'b0);
            model_byte(tbl[i].code, tbl[i].bad_par, 1'b0);
            check("tbl_key", 32'(ps2_key), 32'(tbl[i].exp_key));
            check("tbl_perr", perr_cnt, tbl[i].exp_perr);
            check("tbl_ferr", ferr_cnt, 0);
            check("tbl_tog", tog_cnt, m_tog);
        end

        // Short low glitch on idle clock with data high: a false strobe would raise frame_err
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(40);
        check_all("glitch");

        // Start plus four data bits, then silence until the timeout fires
        send_bits(frame_bits(8'h5A, 1'b0, 1'b0), 5);
        wait_cyc(TOUT + 1);
        m_ferr++; m_ext = 1'b0; m_rel = 1'b0; m_skip = 0;
        check_all("timeout");
        ps2_data = 1'b1;
        wait_cyc(GAP);

        send_frame(8'h16, 1'b0, 1'b0);
        model_byte(8'h16, 1'b0, 1'b0);
        check("after_timeout_key", 32'(ps2_key[9:0]), 32'h216);
        check_all("after_timeout");

        // Reset arriving partway through a frame
        send_bits(frame_bits(8'h3A, 1'b0, 1'b0), 5);
        reset_n = 1'b0;
        wait_cyc(3);
        check("midreset_key", 32'(ps2_key), 32'h0);
        check("midreset_errs", 32'({parity_err, frame_err}), 32'h0);
        reset_n = 1'b1;
        ps2_data = 1'b1;
        m_key = '0; m_ext = 1'b0; m_rel = 1'b0; m_skip = 0;
        wait_cyc(GAP);
        send_frame(8'h3A, 1'b0, 1'b0);
        model_byte(8'h3A, 1'b0, 1'b0);
        check("post_reset_key", 32'(ps2_key), 32'h63A);
        check_all("post_reset");

        // Randomized frames against the model
        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 11));
            case (r)
                0, 1:    b = 8'hE0;
                2, 3:    b = 8'hF0;
                4:       b = 8'hE1;
                5:       b = resp[$urandom_range(0, 5)];
                default: b = 8'($urandom);
            endcase
            r  = int'($urandom_range(0, 9));
            bp = (r == 0);
            bs = (r == 1);
            send_frame(b, bp, bs);
            model_byte(b, bp, bs);
            check_all("rand");
        end

        check("both_err_same_cycle", both_cnt, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
